// File: rtl/vga_scanout.sv
// vga_scanout: 640x480@60 VGA timing, VRAM address walk and centred grey image.
// Define VGA_SCANOUT_BORDER_EN to draw a white 1-pixel ring around the image.
module vga_scanout #(
  parameter int         H_ACTIVE   = 640,
  parameter int         H_FP       = 16,
  parameter int         H_SYNC     = 96,
  parameter int         H_BP       = 48,
  parameter int         V_ACTIVE   = 480,
  parameter int         V_FP       = 10,
  parameter int         V_SYNC     = 2,
  parameter int         V_BP       = 33,
  parameter int         ORIG_DIM   = 400,
  parameter int         INTERP_DIM = 300,
  parameter logic [7:0] BG_LEVEL   = 8'h00
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pix_ce,
  input  logic        image_select,
  input  logic [7:0]  vram_out,
  output logic [31:0] gpu_address,
  output logic [7:0]  vga_r,
  output logic [7:0]  vga_g,
  output logic [7:0]  vga_b,
  output logic        vga_hsync,
  output logic        vga_vsync,
  output logic        vga_blank_n,
  output logic        frame_start
);

  localparam logic [9:0] H_LAST = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0] V_LAST = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [9:0] H_VIS  = 10'(H_ACTIVE);
  localparam logic [9:0] V_VIS  = 10'(V_ACTIVE);
  localparam logic [9:0] HS_BEG = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VS_BEG = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END = 10'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [9:0] OX0    = 10'((H_ACTIVE - ORIG_DIM) / 2);
  localparam logic [9:0] OY0    = 10'((V_ACTIVE - ORIG_DIM) / 2);
  localparam logic [9:0] IX0    = 10'((H_ACTIVE - INTERP_DIM) / 2);
  localparam logic [9:0] IY0    = 10'((V_ACTIVE - INTERP_DIM) / 2);
  localparam logic [9:0] OD     = 10'(ORIG_DIM);
  localparam logic [9:0] ID     = 10'(INTERP_DIM);

`ifdef VGA_SCANOUT_BORDER_EN
  localparam logic [7:0] RING_LEVEL = 8'hFF;
`else
  localparam logic [7:0] RING_LEVEL = BG_LEVEL;
`endif

  typedef struct packed {
    logic win;
    logic ring;
    logic vis;
    logic hs;
    logic vs;
  } s1_t;

  localparam s1_t S1_RST = '{win: 1'b0, ring: 1'b0, vis: 1'b0,
                             hs: 1'b1, vs: 1'b1};

  logic [9:0]  h_cnt;
  logic [9:0]  v_cnt;
  logic [31:0] run_addr;
  logic        dim_sel;
  logic [9:0]  x0;
  logic [9:0]  y0;
  logic [9:0]  dm;
  logic [9:0]  x1;
  logic [9:0]  y1;
  logic        in_win;
  logic        in_box;
  logic        frame_top;
  s1_t         s1;
  s1_t         s1_next;
  logic [7:0]  pix;

  // Window geometry for the frame's latched image size, plus sync decode.
  always_comb begin
    x0        = dim_sel ? IX0 : OX0;
    y0        = dim_sel ? IY0 : OY0;
    dm        = dim_sel ? ID : OD;
    x1        = x0 + dm;
    y1        = y0 + dm;
    in_win    = (h_cnt >= x0) && (h_cnt < x1) &&
                (v_cnt >= y0) && (v_cnt < y1);
    in_box    = (h_cnt + 10'd1 >= x0) && (h_cnt <= x1) &&
                (v_cnt + 10'd1 >= y0) && (v_cnt <= y1);
    frame_top = (h_cnt == 10'd0) && (v_cnt == 10'd0);
    s1_next      = S1_RST;
    s1_next.win  = in_win;
    s1_next.ring = in_box && !in_win;
    s1_next.vis  = (h_cnt < H_VIS) && (v_cnt < V_VIS);
    s1_next.hs   = !((h_cnt >= HS_BEG) && (h_cnt < HS_END));
    s1_next.vs   = !((v_cnt >= VS_BEG) && (v_cnt < VS_END));
  end

  // Raster counters advance one pixel per enabled tick.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (pix_ce) begin
      if (h_cnt == H_LAST) begin
        h_cnt <= '0;
        v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 10'd1;
      end else begin
        h_cnt <= h_cnt + 10'd1;
      end
    end
  end

  // Frame latch, row-major address walk and one-clk frame_start pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dim_sel     <= 1'b0;
      run_addr    <= '0;
      gpu_address <= '0;
      frame_start <= 1'b0;
    end else begin
      frame_start <= pix_ce && frame_top;
      if (pix_ce) begin
        if (frame_top) begin
          dim_sel  <= image_select;
          run_addr <= '0;
        end else if (in_win) begin
          gpu_address <= run_addr;
          run_addr    <= run_addr + 32'd1;
        end
      end
    end
  end

  // First pipeline stage: carry window/sync flags alongside the VRAM fetch.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1 <= S1_RST;
    end else if (pix_ce) begin
      s1 <= s1_next;
    end
  end

  // Pixel select: blanking overrides everything, then image, ring, background.
  always_comb begin
    pix = BG_LEVEL;
    if (!s1.vis) begin
      pix = 8'h00;
    end else if (s1.win) begin
      pix = vram_out;
    end else if (s1.ring) begin
      pix = RING_LEVEL;
    end
  end

  // Output registers, aligned with the fetched pixel data.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vga_r       <= 8'h00;
      vga_g       <= 8'h00;
      vga_b       <= 8'h00;
      vga_hsync   <= 1'b1;
      vga_vsync   <= 1'b1;
      vga_blank_n <= 1'b0;
    end else if (pix_ce) begin
      vga_r       <= pix;
      vga_g       <= pix;
      vga_b       <= pix;
      vga_hsync   <= s1.hs;
      vga_vsync   <= s1.vs;
      vga_blank_n <= s1.vis;
    end
  end

endmodule

// File: tb/tb_vga_scanout.sv
// tb_vga_scanout: directed checks on a full-size and a reduced-geometry scan-out.
// The reduced instance (40x30 raster, 20/14 images) makes whole frames short.
module tb_vga_scanout;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        pix_ce;
  logic        image_select;

  logic [31:0] f_addr;
  logic [7:0]  f_vram, f_r, f_g, f_b;
  logic        f_hs, f_vs, f_bn, f_fs;
  logic [31:0] s_addr;
  logic [7:0]  s_vram, s_r, s_g, s_b;
  logic        s_hs, s_vs, s_bn, s_fs;

  assign f_vram = f_addr[7:0];
  assign s_vram = s_addr[7:0];

  vga_scanout u_full (
    .clk(clk), .reset(reset), .pix_ce(pix_ce),
    .image_select(image_select), .vram_out(f_vram),
    .gpu_address(f_addr), .vga_r(f_r), .vga_g(f_g), .vga_b(f_b),
    .vga_hsync(f_hs), .vga_vsync(f_vs), .vga_blank_n(f_bn),
    .frame_start(f_fs)
  );

  vga_scanout #(
    .H_ACTIVE(32), .H_FP(2), .H_SYNC(4), .H_BP(2),
    .V_ACTIVE(24), .V_FP(2), .V_SYNC(2), .V_BP(2),
    .ORIG_DIM(20), .INTERP_DIM(14)
  ) u_small (
    .clk(clk), .reset(reset), .pix_ce(pix_ce),
    .image_select(image_select), .vram_out(s_vram),
    .gpu_address(s_addr), .vga_r(s_r), .vga_g(s_g), .vga_b(s_b),
    .vga_hsync(s_hs), .vga_vsync(s_vs), .vga_blank_n(s_bn),
    .frame_start(s_fs)
  );

`ifdef VGA_SCANOUT_BORDER_EN
  localparam logic [7:0] RG = 8'hFF;
`else
  localparam logic [7:0] RG = 8'h00;
`endif

  typedef struct {
    bit         full;
    int         ce;
    bit         sel;
    int         f;
    int         h;
    int         v;
    logic [7:0] pix;
    bit         vis;
    bit         hs;
    bit         vs;
    int         addr;
  } vec_t;

  vec_t vt[$];
  int   n_chk = 0;
  int   n_pass = 0;
  int   ce_div = 1;
  int   tk = 0;
  int   cyc = 0;
  int   hs_f, hs_fp, hs_r, vs_f, vs_fp, vs_r, fs_t, fs_tp;
  logic hs_q, vs_q;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic add(bit full, int ce, bit sel, int f, int h, int v,
                     logic [7:0] pix, bit vis, bit hs, bit vs, int addr);
    vec_t e;
    e.full = full; e.ce = ce; e.sel = sel; e.f = f; e.h = h; e.v = v;
    e.pix = pix; e.vis = vis; e.hs = hs; e.vs = vs; e.addr = addr;
    vt.push_back(e);
  endtask

  task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d want %0d", nm, act, exp);
  endtask

  task automatic clear_trk();
    hs_q = 1'b1; vs_q = 1'b1;
    hs_f = 0; hs_fp = 0; hs_r = 0;
    vs_f = 0; vs_fp = 0; vs_r = 0;
    fs_t = 0; fs_tp = 0;
  endtask

  task automatic tick();
    for (int i = 1; i < ce_div; i++) begin
      @(negedge clk) pix_ce = 1'b0;
      @(posedge clk);
    end
    @(negedge clk) pix_ce = 1'b1;
    @(posedge clk);
    #1;
    tk++;
    if (hs_q && !s_hs) begin hs_fp = hs_f; hs_f = cyc; end
    if (!hs_q && s_hs) hs_r = cyc;
    if (vs_q && !s_vs) begin vs_fp = vs_f; vs_f = cyc; end
    if (!vs_q && s_vs) vs_r = cyc;
    if (s_fs) begin fs_tp = fs_t; fs_t = cyc; end
    hs_q = s_hs;
    vs_q = s_vs;
  endtask

  task automatic goto_px(bit full, int f, int h, int v);
    int ht, ft, p;
    ht = full ? 800 : 40;
    ft = full ? 420000 : 1200;
    p = f * ft + v * ht + h;
    if (tk - 2 > p) begin
      n_chk++;
      $display("FAIL order: at pixel %0d, target %0d", tk - 2, p);
    end
    while (tk - 2 < p) tick();
  endtask

  task automatic run_vec(int i);
    vec_t        e;
    string       tag;
    logic [31:0] a;
    logic [23:0] rgb;
    logic        hs, vs, bn;
    e = vt[i];
    tag = $sformatf("vec%0d", i);
    ce_div = e.ce;
    image_select = e.sel;
    goto_px(e.full, e.f, e.h, e.v);
    if (e.full) begin
      a = f_addr; rgb = {f_r, f_g, f_b}; hs = f_hs; vs = f_vs; bn = f_bn;
    end else begin
      a = s_addr; rgb = {s_r, s_g, s_b}; hs = s_hs; vs = s_vs; bn = s_bn;
    end
    check({tag, "_rgb"}, 32'(rgb), 32'({e.pix, e.pix, e.pix}));
    check({tag, "_blank_n"}, 32'(bn), 32'(e.vis));
    check({tag, "_hsync"}, 32'(hs), 32'(e.hs));
    check({tag, "_vsync"}, 32'(vs), 32'(e.vs));
    check({tag, "_addr"}, a, 32'(e.addr));
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    pix_ce = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    tk = 0;
    clear_trk();
  endtask

  task automatic check_rst(string nm);
    check({nm, "_addr"}, s_addr, 32'd0);
    check({nm, "_rgb"}, 32'({s_r, s_g, s_b}), 32'd0);
    check({nm, "_hsync"}, 32'(s_hs), 32'd1);
    check({nm, "_vsync"}, 32'(s_vs), 32'd1);
    check({nm, "_blank_n"}, 32'(s_bn), 32'd0);
    check({nm, "_fs"}, 32'(s_fs), 32'd0);
    check({nm, "_full"},
          32'({f_addr[7:0], f_r, f_g, f_b, f_hs, f_vs, f_bn, f_fs}),
          32'({8'h00, 24'h0, 4'b1100}));
  endtask

  initial begin
    int n_full, n_a, n_b;
    reset = 1'b0;
    pix_ce = 1'b0;
    image_select = 1'b0;
    clear_trk();

    // full-size raster, image_select=0
    add(1,1,0,0,655,0,  8'd0,  0,1,1,0);
    add(1,1,0,0,656,0,  8'd0,  0,0,1,0);
    add(1,1,0,0,751,0,  8'd0,  0,0,1,0);
    add(1,1,0,0,752,0,  8'd0,  0,1,1,0);
    add(1,1,0,0,119,40, RG,    1,1,1,0);
    add(1,1,0,0,120,40, 8'd0,  1,1,1,1);
    add(1,1,0,0,121,40, 8'd1,  1,1,1,2);
    add(1,1,0,0,519,40, 8'd143,1,1,1,399);
    add(1,1,0,0,640,40, 8'd0,  0,1,1,399);
    add(1,1,0,0,120,41, 8'd144,1,1,1,401);
    n_full = vt.size();
    // reduced raster, frame 0 with 20x20 image at (6,2)
    add(0,1,0,0,5,2,   RG,    1,1,1,0);
    add(0,1,0,0,6,2,   8'd0,  1,1,1,1);
    add(0,1,0,0,7,2,   8'd1,  1,1,1,2);
    add(0,1,0,0,25,2,  8'd19, 1,1,1,19);
    add(0,1,0,0,26,2,  RG,    1,1,1,19);
    add(0,1,0,0,27,2,  8'd0,  1,1,1,19);
    add(0,1,0,0,31,2,  8'd0,  1,1,1,19);
    add(0,1,0,0,32,2,  8'd0,  0,1,1,19);
    add(0,1,0,0,34,2,  8'd0,  0,0,1,19);
    add(0,1,0,0,37,2,  8'd0,  0,0,1,19);
    add(0,1,0,0,38,2,  8'd0,  0,1,1,19);
    add(0,1,0,0,6,3,   8'd20, 1,1,1,21);
    // image_select rises mid-frame: frame 0 keeps the 20x20 walk
    add(0,1,1,0,6,10,  8'd160,1,1,1,161);
    add(0,1,1,0,25,21, 8'd143,1,1,1,399);
    add(0,1,1,0,26,21, RG,    1,1,1,399);
    add(0,1,1,0,6,22,  RG,    1,1,1,399);
    // frame 1: 14x14 image at (9,5)
    add(0,1,1,1,6,2,   8'd0,  1,1,1,399);
    add(0,1,1,1,8,5,   RG,    1,1,1,0);
    add(0,1,1,1,9,5,   8'd0,  1,1,1,1);
    add(0,1,1,1,22,5,  8'd13, 1,1,1,13);
    add(0,1,1,1,23,5,  RG,    1,1,1,13);
    add(0,1,1,1,9,6,   8'd14, 1,1,1,15);
    add(0,1,1,1,22,18, 8'd195,1,1,1,195);
    add(0,1,1,1,23,18, RG,    1,1,1,195);
    add(0,1,1,1,15,19, RG,    1,1,1,195);
    add(0,1,1,1,15,20, 8'd0,  1,1,1,195);
    add(0,1,1,1,10,25, 8'd0,  0,1,1,195);
    add(0,1,1,1,10,26, 8'd0,  0,1,0,195);
    add(0,1,1,1,39,27, 8'd0,  0,1,0,195);
    add(0,1,1,1,0,28,  8'd0,  0,1,1,195);
    n_a = vt.size();
    // frame 3 with pix_ce every second clk
    add(0,2,1,3,9,5,   8'd0,  1,1,1,1);
    add(0,2,1,3,10,5,  8'd1,  1,1,1,2);
    add(0,2,1,3,22,18, 8'd195,1,1,1,195);
    add(0,2,1,3,34,20, 8'd0,  0,0,1,195);
    add(0,2,1,3,0,28,  8'd0,  0,1,1,195);
    n_b = vt.size();
    // restart after a mid-frame reset
    add(0,1,1,0,8,5,   RG,    1,1,1,0);
    add(0,1,1,0,9,5,   8'd0,  1,1,1,1);
    add(0,1,1,0,10,5,  8'd1,  1,1,1,2);

    repeat (3) @(posedge clk);
    #1;
    check_rst("rst0");
    @(negedge clk) reset = 1'b1;
    tick();
    check("fs_first_full", 32'(f_fs), 32'd1);
    check("fs_first", 32'(s_fs), 32'd1);
    tick();
    check("fs_drop", 32'(s_fs), 32'd0);
    for (int i = 0; i < n_full; i++) run_vec(i);

    do_reset();
    for (int i = n_full; i < n_a; i++) run_vec(i);
    check("hs_low_ce1", 32'(hs_r - hs_f), 32'd4);
    check("hs_per_ce1", 32'(hs_f - hs_fp), 32'd40);
    check("vs_low_ce1", 32'(vs_r - vs_f), 32'd80);
    check("vs_per_ce1", 32'(vs_f - vs_fp), 32'd1200);
    check("fs_per_ce1", 32'(fs_t - fs_tp), 32'd1200);
    for (int i = n_a; i < n_b; i++) run_vec(i);
    check("hs_low_ce2", 32'(hs_r - hs_f), 32'd8);
    check("hs_per_ce2", 32'(hs_f - hs_fp), 32'd80);
    check("vs_low_ce2", 32'(vs_r - vs_f), 32'd160);
    check("vs_per_ce2", 32'(vs_f - vs_fp), 32'd2400);
    check("fs_per_ce2", 32'(fs_t - fs_tp), 32'd2400);

    goto_px(0, 4, 15, 12);
    check("pre_rst_addr", s_addr, 32'd105);
    check("pre_rst_blank_n", 32'(s_bn), 32'd1);
    reset = 1'b0;
    pix_ce = 1'b0;
    #1;
    check_rst("rst_mid");
    repeat (3) @(posedge clk);
    @(negedge clk) reset = 1'b1;
    tk = 0;
    ce_div = 1;
    clear_trk();
    tick();
    check("fs_restart", 32'(s_fs), 32'd1);
    for (int i = n_b; i < vt.size(); i++) run_vec(i);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/vga_scanout.md
Name: vga_scanout

Overview:
- Downstream display stage of mide_cpu.
- Generates 640x480@60 VGA timing and drives gpu_address into the CPU's VRAM read port.
- Consumes vram_out (8-bit grayscale) and presents the selected image centred on screen.
- Image is either the original 400x400 or the interpolated 300x300, chosen by image_select.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP / H_SYNC / H_BP, 16 / 96 / 48, horizontal porch and sync widths (line total 800)
- V_ACTIVE, 480, visible lines
- V_FP / V_SYNC / V_BP, 10 / 2 / 33, vertical porch and sync widths (frame total 525)
- ORIG_DIM, 400, side of original image (image_select=0)
- INTERP_DIM, 300, side of interpolated image (image_select=1)
- BG_LEVEL, 8'h00, grey level outside the image window

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset (0 = reset)
- pix_ce  in  1  pixel-clock enable; all timing advances only on clk edges with pix_ce=1
- image_select  in  1  0: original, 1: interpolated
- vram_out  in  8  VRAM read data, valid 1 clk after gpu_address changes
- gpu_address  out  32  VRAM read address
- vga_r, vga_g, vga_b  out  8 each  pixel colour (grey: all equal)
- vga_hsync, vga_vsync  out  1 each  sync, active-low
- vga_blank_n  out  1  1 during visible area
- frame_start  out  1  one-clk pulse at pix tick where h=0, v=0

Behaviour:
Reset (reset=0, asynchronous):
- h_cnt, v_cnt, run_addr = 0; gpu_address = 0.
- vga_r/g/b = 0; vga_hsync = vga_vsync = 1; vga_blank_n = 0; frame_start = 0.
- Latched dim = ORIG_DIM.
- Deassertion mid-frame restarts timing at h=0, v=0.

Counters:
- Updated only on pix_ce ticks.
- h_cnt wraps 799 -> 0; on that wrap, v_cnt increments, and wraps 524 -> 0.

Frame latch:
- At the tick with h=0, v=0: latch dim from image_select, set run_addr = 0, pulse frame_start.
- image_select changes mid-frame have no effect until the next frame.

Window:
- X0 = (H_ACTIVE-dim)/2, Y0 = (V_ACTIVE-dim)/2.
- For 400: X0=120, Y0=40. For 300: X0=170, Y0=90.
- in_win = X0 <= h < X0+dim and Y0 <= v < Y0+dim.

Address:
- Row-major, generated incrementally; no multiplier.
- On an in_win tick: gpu_address <= run_addr, then run_addr <= run_addr+1.
- Outside the window, gpu_address holds its value.
- Last address of a frame = dim*dim-1 (159999 or 89999); run_addr never exceeds dim*dim.

Pipeline (2 pix ticks, counter to pins):
- Tick t: address issued.
- Tick t+1: vram_out sampled; vga_r/g/b = vram_out if the delayed in_win=1, else BG_LEVEL.
- hsync, vsync, blank and in_win are delayed 2 ticks, so they align with the pixel data.
- Requires at least 1 clk between an address tick and the following pix_ce tick; pix_ce every cycle is legal.

Sync:
- hsync low for h in [656,751].
- vsync low for v in [490,491].
- blank_n = (h<640 && v<480).
- All three are delayed as above.

Blanking:
- vga_r/g/b forced to 0 whenever the delayed blank_n=0, overriding BG_LEVEL.

Other:
- pix_ce=0: every register holds.
- frame_start fires every frame regardless of image_select.

Optional Feature:
- Macro: VGA_SCANOUT_BORDER_EN.
- Defined: pixels on the 1-pixel ring just outside the window output 8'hFF when visible. Ring = h in {X0-1, X0+dim} with v in [Y0-1, Y0+dim], or v in {Y0-1, Y0+dim} with h in [X0-1, X0+dim].
- Not defined: those pixels output BG_LEVEL.
- Address generation is identical in both builds.

Test Plan:
- Reset, pix_ce=1 constant; measure two frames -> hsync period 800 clk, low 96 clk; vsync period 420000 clk, low 1600 clk; frame_start period 420000.
- image_select=0; VRAM model returns addr[7:0] -> first visible image pixel at screen (120,40) = 8'h00, (121,40) = 8'h01; last address 159999 at (519,439); pixel (119,40) = 8'h00 (BG).
- image_select=1 -> first address at (170,90), last address 89999 at (469,389), 90000 addresses per frame.
- Toggle image_select 0->1 at v=200 -> current frame completes 160000 addresses; next frame uses 300x300.
- pix_ce asserted every 2nd clk -> identical pixel sequence; timing periods doubled in clk.
- Assert reset=0 at v=100, h=300 for 3 clk -> outputs at reset values immediately; after release, frame_start within 1 tick and gpu_address sequence restarts at 0.
